fmq_cmd_framer: RTL and testbench
=================================

Name: fmq_cmd_framer

Overview:
- Command framer/decoder directly downstream of the UART receive AXI-stream and upstream of the per-channel offset register file and the phase-clock reload line.
- Assembles 3-byte frames and validates sync framing, inter-byte gap and address range.
- Emits one-cycle write strobes (channel, 12-bit offset), reload pulses and query responses on the UART transmit stream.
- Replaces ad-hoc shift-register command capture with a resynchronising FSM that applies backpressure.

Parameters:
- OUTPUTS, 88, number of transducer channels; valid write addresses are 0..OUTPUTS-1 (max 128).
- OFFSET_WIDTH, 12, width of the offset payload.
- TIMEOUT, 50000, maximum idle clocks between bytes of one frame (1 ms at 50 MHz).
- ERR_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  received byte valid
- rx_ready  out  1  framer can accept a byte
- tx_data  out  8  response byte
- tx_valid  out  1  response valid
- tx_ready  in  1  UART transmitter accepts the response
- wr_en  out  1  one-cycle offset write strobe
- wr_addr  out  7  channel index
- wr_data  out  OFFSET_WIDTH  phase offset
- reload  out  1  one-cycle pulse that reloads all phase clocks
- err_count  out  ERR_WIDTH  saturating count of framing, timeout and range errors
- busy  out  1  high in any state other than IDLE

Behaviour:
- Frame format:
  - B0 = {1, op[1:0], addr[6:2]}
  - B1 = {0, addr[1:0], off[11:7]}
  - B2 = {0, off[6:0]}
- Opcodes: 00 write offset, 01 reload, 10 query channel count, 11 unknown.
- Reset values: rx_ready=0, tx_valid=0, tx_data=0, wr_en=0, wr_addr=0, wr_data=0, reload=0, err_count=0, busy=0, state=IDLE. rx_ready goes to 1 on the first cycle after reset deasserts.
- A byte is transferred when rx_valid&&rx_ready. tx follows AXI-stream rules: tx_data is held stable while tx_valid=1 and !tx_ready.
- States and transitions:
  - IDLE: B0-type byte (MSB=1) -> GOT1. MSB=0 byte is discarded, err+1.
  - GOT1: MSB=0 byte -> GOT2. MSB=1 byte restarts the frame as a new B0, stays in GOT1, err+1.
  - GOT2: MSB=0 byte -> EXEC. MSB=1 byte restarts as a new B0 -> GOT1, err+1.
  - EXEC (1 cycle, rx_ready=0): performs the op.
    - Write: if addr<OUTPUTS, wr_en=1 with addr/data; otherwise no strobe, err+1.
    - Reload: reload=1.
    - Query: tx_data=OUTPUTS[7:0], tx_valid=1 -> RESP.
    - Unknown: tx_data=0x00, tx_valid=1 -> RESP.
    - Write and reload return to IDLE.
  - RESP: rx_ready=0; when tx_ready is seen, tx_valid=0 -> IDLE.
- Latency: B2 accepted on cycle N -> wr_en, reload or tx_valid on cycle N+1. rx_ready is 0 on N+1. Best-case frame-to-frame throughput is 4 cycles.
- Gap timeout: in GOT1 or GOT2, the gap counter resets on every accepted byte. When it reaches TIMEOUT, go to IDLE, discard the partial frame, err+1. A byte accepted on the same cycle the counter reaches TIMEOUT is processed as a byte; the timeout is ignored.
- err_count saturates at all-ones and never wraps. Only rst clears it.
- wr_addr and wr_data hold their last values between strobes.
- rst asserted mid-frame or in RESP: all state returns to reset values on the next edge. A pending tx_valid is dropped.

Optional Feature:
- Macro FMQ_CMD_ACK_EN.
- Defined:
  - A successful write or reload also enters RESP and sends 0x06.
  - A write rejected for address out of range sends 0x15.
  - Query and unknown behaviour is unchanged.
- Undefined: write and reload produce no tx traffic; behaviour is exactly as above.

Decomposition:
- Package fmq_pkg:
  - opcode localparams OP_WRITE/OP_RELOAD/OP_QUERY/OP_UNKNOWN
  - state encoding (IDLE, GOT1, GOT2, EXEC, RESP)
  - ACK=0x06, NAK=0x15
  - sync-bit position 7
  - field slice positions
- Sub-module fmq_gap_timer:
  - restartable counter with clear input and terminal-count pulse
  - width $clog2(TIMEOUT+1)
  - reusable for the UART link watchdog

Test Plan:
- Send 0x81,0x25,0x7F -> exactly one wr_en cycle, wr_addr=5, wr_data=0x2FF, err_count=0, no tx_valid.
- Send 0xA0,0x00,0x00 -> reload high exactly one cycle, one cycle after B2. Send 0xC0,0x00,0x00 with tx_ready held low 10 cycles -> tx_data=0x58 held stable, rx_ready=0 throughout, returns to IDLE after tx_ready.
- Send 0xE0,0x00,0x00 -> tx_data=0x00 once. Send 0x9F,0x60,0x00 (addr 127) -> no wr_en, err_count=1.
- Send 0x25, then 0x81,0x25,0x81,0x25,0x7F -> a single write, addr 5 / data 0x2FF, err_count=2.
- Send 0x81,0x25, wait TIMEOUT+5 cycles, send 0x7F -> no write, err_count=2 (timeout plus stray byte), state IDLE.
- Assert rst for 1 cycle after 0x81 -> all outputs at reset values. Then send 0x81,0x25,0x7F -> normal write. With FMQ_CMD_ACK_EN defined -> tx 0x06 after the write; 0x9F,0x60,0x00 -> tx 0x15.

Source files
------------

// File: rtl/fmq_pkg.sv
// rtl/fmq_pkg.sv - shared opcodes, FSM encoding, response codes and frame field positions for the command framer
package fmq_pkg;

    // Opcode field values carried in B0[6:5]
    localparam logic [1:0] OP_WRITE   = 2'b00;
    localparam logic [1:0] OP_RELOAD  = 2'b01;
    localparam logic [1:0] OP_QUERY   = 2'b10;
    localparam logic [1:0] OP_UNKNOWN = 2'b11;

    // Framer state encoding
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GOT1 = 3'd1,
        GOT2 = 3'd2,
        EXEC = 3'd3,
        RESP = 3'd4
    } fmq_state_t;

    // Response bytes for acknowledged writes/reloads and rejected writes
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    // The MSB of every byte marks the start of a frame
    localparam int SYNC_BIT = 7;

    // Field slices: B0 = {1, op, addr[6:2]}, B1 = {0, addr[1:0], off[11:7]}, B2 = {0, off[6:0]}
    localparam int B0_OP_HI   = 6;
    localparam int B0_OP_LO   = 5;
    localparam int B0_ADDR_HI = 4;
    localparam int B0_ADDR_LO = 0;
    localparam int B1_ADDR_HI = 6;
    localparam int B1_ADDR_LO = 5;
    localparam int B1_OFF_HI  = 4;
    localparam int B1_OFF_LO  = 0;
    localparam int B2_OFF_HI  = 6;
    localparam int B2_OFF_LO  = 0;

    // Widths of the assembled fields
    localparam int ADDR_W      = 7;
    localparam int FRAME_OFF_W = 12;

endpackage

// File: rtl/fmq_cmd_framer_if.sv
// rtl/fmq_cmd_framer_if.sv - rx/tx byte streams plus offset-write and reload lines of the command framer
interface fmq_cmd_framer_if #(
    parameter int OFFSET_WIDTH = 12
);
    // UART receive stream into the framer
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic                    rx_ready;
    // UART transmit stream out of the framer
    logic [7:0]              tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    // Offset register file write port and phase-clock reload
    logic                    wr_en;
    logic [6:0]              wr_addr;
    logic [OFFSET_WIDTH-1:0] wr_data;
    logic                    reload;

    // Framer side
    modport master (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid, wr_en, wr_addr, wr_data, reload
    );

    // Environment side (UART, register file, phase clocks)
    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid, wr_en, wr_addr, wr_data, reload
    );
endinterface

// File: rtl/fmq_gap_timer.sv
// rtl/fmq_gap_timer.sv - restartable idle counter with a one-shot terminal-count pulse
module fmq_gap_timer #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tc
);
    localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] TC_VAL = W'(TIMEOUT);

    logic [W-1:0] cnt;
    logic         fired;

    // Count idle cycles since the last clear; park at TIMEOUT and remember the pulse was given
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt   <= '0;
            fired <= 1'b0;
        end else if (cnt != TC_VAL) begin
            cnt <= cnt + 1'b1;
        end else begin
            fired <= 1'b1;
        end
    end

    // A clear on the terminal cycle wins, so an event arriving just in time is never treated as a timeout
    assign tc = !clear && !fired && (cnt == TC_VAL);

endmodule

// File: rtl/fmq_cmd_framer.sv
// rtl/fmq_cmd_framer.sv - 3-byte command framer/decoder; FMQ_CMD_ACK_EN adds ACK/NAK responses to writes and reloads
module fmq_cmd_framer
    import fmq_pkg::*;
#(
    parameter int OUTPUTS      = 88,
    parameter int OFFSET_WIDTH = 12,
    parameter int TIMEOUT      = 50000,
    parameter int ERR_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    fmq_cmd_framer_if.master     bus,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic                 busy
);
    localparam logic [7:0] OUT_LIM   = 8'(OUTPUTS);
    localparam logic [7:0] CHAN_RESP = 8'(OUTPUTS);

    fmq_state_t state;

    // Captured payload bits of B0 and B1 (sync bits are implied by the state)
    logic [6:0] b0_q;
    logic [6:0] b1_q;

    logic                   rx_fire;
    logic                   sync;
    logic [1:0]             frm_op;
    logic [ADDR_W-1:0]      frm_addr;
    logic [FRAME_OFF_W-1:0] frm_off;
    logic                   addr_ok;
    logic                   gap_clear;
    logic                   gap_tc;
    logic                   err_event;

    assign rx_fire  = bus.rx_valid && bus.rx_ready;
    assign sync     = bus.rx_data[SYNC_BIT];
    assign frm_op   = b0_q[B0_OP_HI:B0_OP_LO];
    assign frm_addr = {b0_q[B0_ADDR_HI:B0_ADDR_LO], b1_q[B1_ADDR_HI:B1_ADDR_LO]};
    assign frm_off  = {b1_q[B1_OFF_HI:B1_OFF_LO], bus.rx_data[B2_OFF_HI:B2_OFF_LO]};
    assign addr_ok  = ({1'b0, frm_addr} < OUT_LIM);

    // The gap timer only runs while a frame is partially assembled
    assign gap_clear = rx_fire || !((state == GOT1) || (state == GOT2));

    fmq_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (gap_clear),
        .tc    (gap_tc)
    );

    // Flag framing, timeout and range errors seen this cycle
    always_comb begin
        err_event = 1'b0;
        case (state)
            IDLE: begin
                if (rx_fire && !sync) err_event = 1'b1;
            end
            GOT1: begin
                if (rx_fire)     err_event = sync;
                else if (gap_tc) err_event = 1'b1;
            end
            GOT2: begin
                if (rx_fire) begin
                    if (sync)                                  err_event = 1'b1;
                    else if ((frm_op == OP_WRITE) && !addr_ok) err_event = 1'b1;
                end else if (gap_tc) begin
                    err_event = 1'b1;
                end
            end
            default: err_event = 1'b0;
        endcase
    end

    // Saturating error counter; only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_event && (err_count != {ERR_WIDTH{1'b1}})) begin
            err_count <= err_count + 1'b1;
        end
    end

    // Frame assembly and command execution FSM; every output is registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            b0_q         <= '0;
            b1_q         <= '0;
            bus.rx_ready <= 1'b0;
            bus.tx_valid <= 1'b0;
            bus.tx_data  <= '0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            bus.reload   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            bus.wr_en  <= 1'b0;
            bus.reload <= 1'b0;
            case (state)
                IDLE: begin
                    bus.rx_ready <= 1'b1;
                    if (rx_fire && sync) begin
                        b0_q  <= bus.rx_data[6:0];
                        state <= GOT1;
                        busy  <= 1'b1;
                    end
                end

                GOT1: begin
                    if (rx_fire) begin
                        if (sync) begin
                            // A new B0 mid-frame restarts assembly from this byte
                            b0_q <= bus.rx_data[6:0];
                        end else begin
                            b1_q  <= bus.rx_data[6:0];
                            state <= GOT2;
                        end
                    end else if (gap_tc) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                GOT2: begin
                    if (rx_fire) begin
                        if (sync) begin
                            b0_q  <= bus.rx_data[6:0];
                            state <= GOT1;
                        end else begin
                            // B2 accepted: act now so strobes appear on the next cycle
                            state        <= EXEC;
                            bus.rx_ready <= 1'b0;
                            case (frm_op)
                                OP_WRITE: begin
                                    if (addr_ok) begin
                                        bus.wr_en   <= 1'b1;
                                        bus.wr_addr <= frm_addr;
                                        bus.wr_data <= OFFSET_WIDTH'(frm_off);
`ifdef FMQ_CMD_ACK_EN
                                        bus.tx_data  <= ACK;
                                        bus.tx_valid <= 1'b1;
                                    end else begin
                                        bus.tx_data  <= NAK;
                                        bus.tx_valid <= 1'b1;
`endif
                                    end
                                end
                                OP_RELOAD: begin
                                    bus.reload <= 1'b1;
`ifdef FMQ_CMD_ACK_EN
                                    bus.tx_data  <= ACK;
                                    bus.tx_valid <= 1'b1;
`endif
                                end
                                OP_QUERY: begin
                                    bus.tx_data  <= CHAN_RESP;
                                    bus.tx_valid <= 1'b1;
                                end
                                default: begin
                                    bus.tx_data  <= 8'h00;
                                    bus.tx_valid <= 1'b1;
                                end
                            endcase
                        end
                    end else if (gap_tc) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                EXEC: begin
                    // A response already taken in this cycle needs no RESP wait
                    if (!bus.tx_valid || bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        bus.rx_ready <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        state <= RESP;
                    end
                end

                RESP: begin
                    if (bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        bus.rx_ready <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: begin
                    state        <= IDLE;
                    bus.rx_ready <= 1'b0;
                    bus.tx_valid <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fmq_cmd_framer.sv
// tb/tb_fmq_cmd_framer.sv - self-checking bench for fmq_cmd_framer with a frame-level reference model
module tb_fmq_cmd_framer;

    localparam int OUTPUTS = 88;
    localparam int TO      = 64;
    localparam int OW      = 12;
    localparam int EW      = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fmq_cmd_framer_if #(.OFFSET_WIDTH(OW)) bus ();
    logic [EW-1:0] err_count;
    logic          busy;

    fmq_cmd_framer #(
        .OUTPUTS      (OUTPUTS),
        .OFFSET_WIDTH (OW),
        .TIMEOUT      (TO),
        .ERR_WIDTH    (EW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .err_count (err_count),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame bytes collected so far, and whether a command is being executed or answered
    logic        m_rx_ready = 1'b0, m_tx_valid = 1'b0, m_wr_en = 1'b0, m_reload = 1'b0, m_busy = 1'b0;
    logic [7:0]  m_tx_data = 8'h00;
    logic [6:0]  m_wr_addr = 7'd0;
    logic [11:0] m_wr_data = 12'd0;
    logic [7:0]  m_err = 8'd0;
    logic [7:0]  fb0 = 8'h00, fb1 = 8'h00;
    int          nb = 0;       // bytes of the current frame held
    int          phase = 0;    // 0 accepting, 1 executing, 2 waiting for tx_ready
    int          cyc = 0;
    int          last_acc = 0;
    bit          model_on = 1'b0;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    task automatic model_exec(input logic [7:0] b2);
        logic [6:0]  a;
        logic [11:0] o;
        a = {fb0[4:0], fb1[6:5]};
        o = {fb1[4:0], b2[6:0]};
        case (fb0[6:5])
            2'd0: begin
                if (int'(a) < OUTPUTS) begin
                    m_wr_en = 1'b1; m_wr_addr = a; m_wr_data = o;
`ifdef FMQ_CMD_ACK_EN
                    m_tx_valid = 1'b1; m_tx_data = 8'h06;
`endif
                end else begin
                    m_err = sat_inc(m_err);
`ifdef FMQ_CMD_ACK_EN
                    m_tx_valid = 1'b1; m_tx_data = 8'h15;
`endif
                end
            end
            2'd1: begin
                m_reload = 1'b1;
`ifdef FMQ_CMD_ACK_EN
                m_tx_valid = 1'b1; m_tx_data = 8'h06;
`endif
            end
            2'd2: begin m_tx_valid = 1'b1; m_tx_data = 8'(OUTPUTS); end
            default: begin m_tx_valid = 1'b1; m_tx_data = 8'h00; end
        endcase
        phase = 1;
    endtask

    task automatic model_step();
        logic acc;
        cyc++;
        if (rst) begin
            m_rx_ready = 0; m_tx_valid = 0; m_tx_data = 0; m_wr_en = 0; m_wr_addr = 0;
            m_wr_data = 0; m_reload = 0; m_err = 0; m_busy = 0; nb = 0; phase = 0;
            model_on = 1'b1;
            return;
        end
        acc = bus.rx_valid && m_rx_ready;
        m_wr_en = 0;
        m_reload = 0;
        if (phase == 1) begin
            if (m_tx_valid && !bus.tx_ready) phase = 2;
            else begin m_tx_valid = 0; phase = 0; end
        end else if (phase == 2) begin
            if (bus.tx_ready) begin m_tx_valid = 0; phase = 0; end
        end else if (acc) begin
            last_acc = cyc;
            if (bus.rx_data[7]) begin
                if (nb != 0) m_err = sat_inc(m_err);
                fb0 = bus.rx_data;
                nb = 1;
            end else if (nb == 0) begin
                m_err = sat_inc(m_err);
            end else if (nb == 1) begin
                fb1 = bus.rx_data;
                nb = 2;
            end else begin
                nb = 0;
                model_exec(bus.rx_data);
            end
        end else if (nb != 0 && (cyc - last_acc) == TO + 1) begin
            nb = 0;
            m_err = sat_inc(m_err);
        end
        m_rx_ready = (phase == 0);
        m_busy = (nb != 0) || (phase != 0);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Cycle-by-cycle comparison plus event counters used by the directed checks
    int         mon_cyc = 0, wr_cnt = 0, rl_cnt = 0, tx_cnt = 0, wr_cyc = 0, rl_cyc = 0;
    logic [7:0] last_tx = 8'h00;
    logic       prev_txv = 1'b0;

    initial forever begin
        @(negedge clk);
        mon_cyc++;
        if (model_on) begin
            chk("rx_ready", 32'(bus.rx_ready), 32'(m_rx_ready));
            chk("tx_valid", 32'(bus.tx_valid), 32'(m_tx_valid));
            chk("tx_data", 32'(bus.tx_data), 32'(m_tx_data));
            chk("wr_en", 32'(bus.wr_en), 32'(m_wr_en));
            chk("wr_addr", 32'(bus.wr_addr), 32'(m_wr_addr));
            chk("wr_data", 32'(bus.wr_data), 32'(m_wr_data));
            chk("reload", 32'(bus.reload), 32'(m_reload));
            chk("err_count", 32'(err_count), 32'(m_err));
            chk("busy", 32'(busy), 32'(m_busy));
        end
        if (bus.wr_en === 1'b1) begin wr_cnt++; wr_cyc = mon_cyc; end
        if (bus.reload === 1'b1) begin rl_cnt++; rl_cyc = mon_cyc; end
        if (bus.tx_valid === 1'b1 && !prev_txv) begin tx_cnt++; last_tx = bus.tx_data; end
        prev_txv = (bus.tx_valid === 1'b1);
    end

    // Present a byte from a negedge and return at the negedge after it is accepted
    task automatic send(input logic [7:0] b);
        int n;
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        n = 0;
        while (bus.rx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_wait: rx_ready stayed low, byte 0x%02h", b);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send(a); send(b); send(c);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    int w0, r0, t0;

    initial begin
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rx_ready_after_rst", 32'(bus.rx_ready), 32'd1);

        // Basic write: addr 5, offset 0x2FF
        w0 = wr_cnt; t0 = tx_cnt;
        send3(8'h81, 8'h25, 8'h7F);
        chk("w1_wr_en", 32'(bus.wr_en), 32'd1);
        chk("w1_addr", 32'(bus.wr_addr), 32'd5);
        chk("w1_data", 32'(bus.wr_data), 32'h2FF);
        chk("w1_rx_ready_exec", 32'(bus.rx_ready), 32'd0);
        idle(3);
        chk("w1_count", 32'(wr_cnt - w0), 32'd1);
        chk("w1_err", 32'(err_count), 32'd0);
`ifdef FMQ_CMD_ACK_EN
        chk("w1_ack", 32'(last_tx), 32'h06);
        chk("w1_tx_count", 32'(tx_cnt - t0), 32'd1);
`else
        chk("w1_tx_count", 32'(tx_cnt - t0), 32'd0);
`endif
        chk("w1_addr_hold", 32'(bus.wr_addr), 32'd5);

        // Reload pulse
        r0 = rl_cnt;
        send3(8'hA0, 8'h00, 8'h00);
        chk("rl_high", 32'(bus.reload), 32'd1);
        @(negedge clk);
        chk("rl_low", 32'(bus.reload), 32'd0);
        idle(2);
        chk("rl_count", 32'(rl_cnt - r0), 32'd1);

        // Query held off by tx_ready for 10 cycles
        bus.tx_ready = 1'b0;
        send3(8'hC0, 8'h00, 8'h00);
        for (int i = 0; i < 10; i++) begin
            chk("q_valid", 32'(bus.tx_valid), 32'd1);
            chk("q_data", 32'(bus.tx_data), 32'h58);
            chk("q_rx_ready", 32'(bus.rx_ready), 32'd0);
            @(negedge clk);
        end
        bus.tx_ready = 1'b1;
        @(negedge clk);
        chk("q_done_valid", 32'(bus.tx_valid), 32'd0);
        chk("q_done_busy", 32'(busy), 32'd0);

        // Unknown opcode answers 0x00 once
        t0 = tx_cnt;
        send3(8'hE0, 8'h00, 8'h00);
        chk("u_valid", 32'(bus.tx_valid), 32'd1);
        chk("u_data", 32'(bus.tx_data), 32'h00);
        idle(3);
        chk("u_count", 32'(tx_cnt - t0), 32'd1);

        // Out-of-range address 127
        do_reset();
        w0 = wr_cnt;
        send3(8'h9F, 8'h60, 8'h00);
        idle(2);
        chk("oor_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("oor_err", 32'(err_count), 32'd1);
`ifdef FMQ_CMD_ACK_EN
        chk("oor_nak", 32'(last_tx), 32'h15);
`endif

        // Stray byte then a restarted frame
        do_reset();
        w0 = wr_cnt;
        send(8'h25);
        send3(8'h81, 8'h25, 8'h81);
        send(8'h25);
        send(8'h7F);
        idle(2);
        chk("resync_writes", 32'(wr_cnt - w0), 32'd1);
        chk("resync_addr", 32'(bus.wr_addr), 32'd5);
        chk("resync_data", 32'(bus.wr_data), 32'h2FF);
        chk("resync_err", 32'(err_count), 32'd2);

        // Gap timeout well past the limit
        do_reset();
        w0 = wr_cnt;
        send(8'h81); send(8'h25);
        idle(TO + 5);
        send(8'h7F);
        idle(2);
        chk("to_no_write", 32'(wr_cnt - w0), 32'd0);
        chk("to_err", 32'(err_count), 32'd2);
        chk("to_idle", 32'(busy), 32'd0);

        // Byte landing exactly on the terminal cycle is still taken
        do_reset();
        w0 = wr_cnt;
        send(8'h81);
        idle(TO);
        send(8'h25); send(8'h7F);
        idle(2);
        chk("edge_write", 32'(wr_cnt - w0), 32'd1);
        chk("edge_err", 32'(err_count), 32'd0);

        // One cycle later it is too late
        do_reset();
        w0 = wr_cnt;
        send(8'h81);
        idle(TO + 1);
        send(8'h25); send(8'h7F);
        idle(2);
        chk("late_write", 32'(wr_cnt - w0), 32'd0);
        chk("late_err", 32'(err_count), 32'd3);

        // Reset mid-frame, then a normal write
        send(8'h81);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_addr", 32'(bus.wr_addr), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(err_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        send3(8'h81, 8'h25, 8'h7F);
        chk("post_rst_wr", 32'(bus.wr_en), 32'd1);
        chk("post_rst_data", 32'(bus.wr_data), 32'h2FF);
        idle(2);

        // Reset while a response is pending drops it
        bus.tx_ready = 1'b0;
        send3(8'hC0, 8'h00, 8'h00);
        idle(2);
        rst = 1'b1;
        @(negedge clk);
        chk("resp_rst_valid", 32'(bus.tx_valid), 32'd0);
        chk("resp_rst_data", 32'(bus.tx_data), 32'd0);
        rst = 1'b0;
        bus.tx_ready = 1'b1;
        @(negedge clk);

        // Back-to-back frames: write then reload four cycles apart
        w0 = wr_cnt; r0 = rl_cnt;
        send3(8'h81, 8'h25, 8'h7F);
        send3(8'hA0, 8'h00, 8'h00);
        idle(2);
        chk("b2b_write", 32'(wr_cnt - w0), 32'd1);
        chk("b2b_reload", 32'(rl_cnt - r0), 32'd1);
        chk("b2b_spacing", 32'(rl_cyc - wr_cyc), 32'd4);

        // Error counter saturates
        do_reset();
        for (int i = 0; i < 260; i++) send(8'h00);
        idle(1);
        chk("sat_err", 32'(err_count), 32'hFF);
        send(8'h01);
        idle(1);
        chk("sat_hold", 32'(err_count), 32'hFF);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
